gray2rgb_serializer: RTL and testbench
======================================

Name: gray2rgb_serializer

Overview:
- Converts the grayscale pixel stream at the end of the pipeline back into an RGB byte stream for the host or display transmit path.
- Each accepted gray pixel is replicated into R, G and B channel beats, emitted one per cycle over a valid/ready byte interface.
- A frame pixel counter marks the final byte of each frame.
- Sits after the Sobel/gray stages and before the transmit/output adapter.

Parameters:
- WIDTH_P, 8, bit width of the gray input pixel and of each output channel beat.
- FRAME_PIXELS_P, 307200, pixels per frame; sets where last_o fires. Must be >= 1.

Ports:
- clk_i  input  1  clock
- rstn_i  input  1  reset, asynchronous, active-low
- valid_i  input  1  upstream gray pixel valid
- ready_o  output  1  block can accept a gray pixel this cycle
- gray_i  input  WIDTH_P  gray pixel value
- valid_o  output  1  output beat valid
- ready_i  input  1  downstream accepts output beat
- data_o  output  WIDTH_P  channel value (equal to the held gray value)
- channel_o  output  2  channel index of current beat: 0=R, 1=G, 2=B; 3 never driven
- last_o  output  1  high on the B beat of the final pixel of a frame

Behaviour:
- Clock and reset: one clock, clk_i. Reset rstn_i is asynchronous and active-low.
- Reset state: applies immediately while rstn_i is low, independent of clk_i.
  - valid_o=0, data_o=0, channel_o=0, last_o=0, ready_o=1.
  - Pixel counter=0, hold register empty.
- Handshakes:
  - Input transfer when valid_i && ready_o.
  - Output transfer when valid_o && ready_i.
- FSM states: EMPTY and EMIT. The beat index 0..2 is a sub-counter within EMIT.
  - EMPTY: valid_o=0, ready_o=1. On an input transfer, latch gray_i, set beat=0, go to EMIT.
  - EMIT, output signals: valid_o=1, data_o=held value, channel_o=beat.
  - EMIT, beat advance: on an output transfer with beat<2, beat increments.
  - EMIT, beat 2 transfer:
    - The pixel is done and the pixel counter advances.
    - If an input transfer occurs in the same cycle, latch the new pixel, set beat=0 and stay in EMIT (back-to-back).
    - Otherwise go to EMPTY.
- ready_o = EMPTY || (EMIT && beat==2 && ready_i).
  - This is a combinational path from ready_i to ready_o.
  - Sustained throughput is 1 pixel per 3 cycles, with no bubble between pixels.
- Latency: the first beat (R) is presented the cycle after the input transfer.
- Output stability: while valid_o && !ready_i, data_o, channel_o and last_o hold stable. valid_o never deasserts without a transfer.
- Input ignore: gray_i/valid_i are ignored when ready_o=0. No data loss or overwrite of the held pixel.
- Pixel counter:
  - Width is $clog2(FRAME_PIXELS_P), minimum 1 bit.
  - Increments on each B-beat transfer.
  - When it equals FRAME_PIXELS_P-1, last_o=1 during that pixel's B beat; otherwise last_o=0.
  - On the B-beat transfer at FRAME_PIXELS_P-1 it wraps to 0.
  - With FRAME_PIXELS_P=1, last_o is set on every B beat.
- Reset mid-operation: the partial pixel is discarded, outputs return to reset values immediately, and the counter clears. The first pixel after reset starts a new frame at R.
- Widths: no arithmetic on data; data_o is a straight copy of the held WIDTH_P value. No truncation or saturation.

Test Plan:
- Reset then single pixel: gray_i=0x5A, ready_i=1 -> beats (0x5A,ch0),(0x5A,ch1),(0x5A,ch2) on 3 consecutive cycles starting the cycle after accept. ready_o low during R/G beats, high during B beat. last_o=0 with FRAME_PIXELS_P=4.
- Back-to-back streaming: valid_i held high with pixels 0x10,0x20,0x30, ready_i=1 -> 9 contiguous beats R,G,B per pixel with no gaps. Each second pixel is accepted exactly on the prior B beat.
- Backpressure: ready_i=0 for 5 cycles while the G beat of 0xC3 is presented -> data_o=0xC3 and channel_o=1 stay stable and valid_o stays 1. ready_o=0 throughout, and a new gray_i=0xFF is not captured.
- Frame marking with FRAME_PIXELS_P=4: stream 9 pixels -> last_o=1 only on the B beats of pixels 4 and 8 (1-based). The counter wraps and pixel 9 shows last_o=0.
- Reset mid-pixel: assert rstn_i low during the G beat of 0x77 -> valid_o=0 and ready_o=1 asynchronously. After release, pixel 0x01 emits starting at ch0, and last_o timing restarts from pixel 1 of a new frame.
- Random valid_i/ready_i toggling over 1000 pixels -> scoreboard matches every pixel as 3 identical beats in R,G,B order, with no drops or duplicates.

Source files
------------

// File: rtl/gray2rgb_serializer.sv
// gray2rgb_serializer
// Replicates each accepted gray pixel into three channel beats (R, G, B), emitted one per
// cycle on a valid/ready byte interface. A frame pixel counter flags the B beat of the last
// pixel of each frame on last_o.
//
// Ports:
//   clk_i      clock
//   rstn_i     asynchronous active-low reset
//   valid_i    upstream gray pixel valid
//   ready_o    block can accept a gray pixel this cycle (combinational from ready_i)
//   gray_i     gray pixel value
//   valid_o    output beat valid
//   ready_i    downstream accepts output beat
//   data_o     channel value (copy of the held gray pixel)
//   channel_o  channel index of current beat: 0=R, 1=G, 2=B
//   last_o     high on the B beat of the final pixel of a frame

module gray2rgb_serializer #(
  parameter int unsigned WIDTH_P        = 8,
  parameter int unsigned FRAME_PIXELS_P = 307200
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH_P-1:0] gray_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH_P-1:0] data_o,
  output logic [1:0]         channel_o,
  output logic               last_o
);

  localparam int unsigned CntW = (FRAME_PIXELS_P > 1) ? $clog2(FRAME_PIXELS_P) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_PIXELS_P - 1);

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StEmit  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [1:0]         beat_q, beat_d;
  logic [WIDTH_P-1:0] hold_q, hold_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic in_xfer;
  logic out_xfer;
  logic beat_is_b;

  assign beat_is_b = (beat_q == 2'd2);

  // Accept a new pixel while idle, or in the same cycle the B beat leaves (no bubble).
  assign ready_o   = (state_q == StEmpty) || ((state_q == StEmit) && beat_is_b && ready_i);
  assign valid_o   = (state_q == StEmit);
  assign data_o    = hold_q;
  assign channel_o = beat_q;
  assign last_o    = (state_q == StEmit) && beat_is_b && (cnt_q == LastCnt);

  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = valid_o && ready_i;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;

    case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          hold_d  = gray_i;
          beat_d  = 2'd0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (out_xfer) begin
          if (!beat_is_b) begin
            beat_d = beat_q + 2'd1;
          end else begin
            cnt_d  = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
            beat_d = 2'd0;
            if (in_xfer) begin
              hold_d = gray_i;
            end else begin
              state_d = StEmpty;
            end
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StEmpty;
      beat_q  <= 2'd0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gray2rgb_serializer.sv
// Directed bench for gray2rgb_serializer with FRAME_PIXELS_P=4, finishing with a randomised
// valid/ready scoreboard run.

module tb_gray2rgb_serializer;

  localparam int unsigned W      = 8;
  localparam int unsigned FRAMEP = 4;

  logic         clk;
  logic         rstn;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] gray_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] data_o;
  logic [1:0]   channel_o;
  logic         last_o;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;  // expected frame pixel counter
  logic [W-1:0] pix_list[$];

  gray2rgb_serializer #(
    .WIDTH_P        (W),
    .FRAME_PIXELS_P (FRAMEP)
  ) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .gray_i    (gray_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .channel_o (channel_o),
    .last_o    (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [W-1:0] d, input int ch,
                          input logic lst);
    chk({tag, " valid"}, 32'(valid_o), 32'd1);
    chk({tag, " data"}, 32'(data_o), 32'(d));
    chk({tag, " chan"}, 32'(channel_o), 32'(ch));
    chk({tag, " last"}, 32'(last_o), 32'(lst));
  endtask

  // Streams pix_list back to back with ready_i=1, checking every beat against the model.
  task automatic stream(input string tag);
    int n;
    n       = pix_list.size();
    valid_i = 1'b1;
    ready_i = 1'b1;
    gray_i  = pix_list[0];
    #1;
    chk({tag, " ready idle"}, 32'(ready_o), 32'd1);
    tick();
    for (int p = 0; p < n; p++) begin
      for (int b = 0; b < 3; b++) begin
        chk_beat(tag, pix_list[p], b, (b == 2) && (exp_cnt == int'(FRAMEP) - 1));
        chk({tag, " ready"}, 32'(ready_o), 32'(b == 2));
        if (b == 2) begin
          exp_cnt = (exp_cnt == int'(FRAMEP) - 1) ? 0 : exp_cnt + 1;
          if (p < n - 1) gray_i = pix_list[p + 1];
          else valid_i = 1'b0;
        end
        tick();
      end
    end
    chk({tag, " drained"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    logic [W-1:0] sb[$];
    int exp_beat;
    int accepted;
    int cycles;
    logic exp_ready;

    rstn    = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    gray_i  = '0;

    // Reset values before any clock edge
    #3;
    chk("rst valid", 32'(valid_o), 32'd0);
    chk("rst ready", 32'(ready_o), 32'd1);
    chk("rst data", 32'(data_o), 32'd0);
    chk("rst chan", 32'(channel_o), 32'd0);
    chk("rst last", 32'(last_o), 32'd0);
    #9;
    rstn = 1'b1;
    tick();

    // Single pixel
    valid_i = 1'b1;
    gray_i  = 8'h5A;
    ready_i = 1'b1;
    #1;
    chk("single ready accept", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0;
    #1;
    chk_beat("single R", 8'h5A, 0, 1'b0);
    chk("single ready R", 32'(ready_o), 32'd0);
    tick();
    chk_beat("single G", 8'h5A, 1, 1'b0);
    chk("single ready G", 32'(ready_o), 32'd0);
    tick();
    chk_beat("single B", 8'h5A, 2, 1'b0);
    chk("single ready B", 32'(ready_o), 32'd1);
    tick();
    chk("single done", 32'(valid_o), 32'd0);
    exp_cnt = 1;

    // Back-to-back: third pixel here is frame pixel 4, so last_o fires on 0x30's B beat
    pix_list = '{8'h10, 8'h20, 8'h30};
    stream("b2b");

    // Backpressure on the G beat of 0xC3; 0xFF offered meanwhile must not be captured
    valid_i = 1'b1;
    gray_i  = 8'hC3;
    ready_i = 1'b1;
    tick();
    gray_i = 8'hFF;
    chk_beat("bp R", 8'hC3, 0, 1'b0);
    tick();
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_beat("bp stall G", 8'hC3, 1, 1'b0);
      chk("bp stall ready", 32'(ready_o), 32'd0);
      tick();
    end
    ready_i = 1'b1;
    valid_i = 1'b0;
    chk_beat("bp G", 8'hC3, 1, 1'b0);
    tick();
    chk_beat("bp B", 8'hC3, 2, 1'b0);
    tick();
    chk("bp no capture", 32'(valid_o), 32'd0);
    exp_cnt = 1;

    // Reset mid-pixel during the G beat of 0x77
    valid_i = 1'b1;
    gray_i  = 8'h77;
    tick();
    valid_i = 1'b0;
    tick();
    chk_beat("mid G", 8'h77, 1, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid rst valid", 32'(valid_o), 32'd0);
    chk("mid rst ready", 32'(ready_o), 32'd1);
    chk("mid rst chan", 32'(channel_o), 32'd0);
    tick();
    #2;
    rstn    = 1'b1;
    exp_cnt = 0;
    tick();

    // Frame marking: 9 pixels, last_o on pixels 4 and 8 only
    pix_list = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    stream("frame");

    // Random valid/ready over 1000 pixels against a one-deep scoreboard
    exp_beat = 0;
    accepted = 0;
    cycles   = 0;
    while ((accepted < 1000 || sb.size() != 0) && cycles < 20000) begin
      valid_i = (accepted < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      ready_i = 1'($urandom_range(0, 3) != 0);
      gray_i  = W'($urandom);
      #1;
      exp_ready = (sb.size() == 0) || (exp_beat == 2 && ready_i);
      chk("rnd ready", 32'(ready_o), 32'(exp_ready));
      chk("rnd valid", 32'(valid_o), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        chk("rnd data", 32'(data_o), 32'(sb[0]));
        chk("rnd chan", 32'(channel_o), 32'(exp_beat));
        chk("rnd last", 32'(last_o), 32'(exp_beat == 2 && exp_cnt == int'(FRAMEP) - 1));
        if (ready_i) begin
          if (exp_beat == 2) begin
            void'(sb.pop_front());
            exp_beat = 0;
            exp_cnt  = (exp_cnt == int'(FRAMEP) - 1) ? 0 : exp_cnt + 1;
          end else begin
            exp_beat++;
          end
        end
      end
      if (valid_i && exp_ready) begin
        sb.push_back(gray_i);
        accepted++;
      end
      tick();
      cycles++;
    end
    chk("rnd completed in budget", 32'(cycles < 20000), 32'd1);
    chk("rnd accepted", 32'(accepted), 32'd1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
